// File: rtl/shift_load_pkg.sv
// ----------------------------------------------------------------------------
// shift_load_pkg
//
// Shared definitions for the program-word load sequencer:
//   - state_t   : controller state encoding (IDLE, SHIFT, PRESENT, DONE)
//   - WORD_W    : width of one program word (Hack instruction width)
//   - BIT_CNT_W : width of the per-word bit counter
//   - is_last_bit() : true when the bit counter addresses the final bit
//
// Imported by shift_load_ctrl and shift_load_timeout.
// ----------------------------------------------------------------------------
package shift_load_pkg;

    localparam int WORD_W    = 16;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The counter holds the number of bits already accepted for the current
    // word, so the bit being accepted while it reads WORD_W-1 completes it.
    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(WORD_W - 1);
    endfunction

endpackage

// File: rtl/shift_load_timeout.sv
// ----------------------------------------------------------------------------
// shift_load_timeout
//
// Idle-cycle counter used to abandon a stalled partial word. Counts cycles
// while i_count is high; o_expire is a combinational strobe during the
// TIMEOUT-th consecutive counted cycle, after which the counter restarts.
// Only instantiated by shift_load_ctrl when SHIFT_LOAD_TIMEOUT_EN is defined.
//
// Parameters:
//   TIMEOUT  number of consecutive counted cycles before expiry (>= 2)
//
// Ports:
//   clk       in   system clock, rising edge
//   resetb    in   asynchronous active-low reset
//   i_count   in   this cycle is an idle cycle to be counted
//   i_clear   in   restart the count (has priority over i_count)
//   o_expire  out  TIMEOUT consecutive idle cycles reached (1-cycle strobe)
// ----------------------------------------------------------------------------
module shift_load_timeout
    import shift_load_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_count,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("shift_load_timeout: TIMEOUT must be >= 2");
    end

    // r_cnt holds the idle cycles already seen, so the cycle in which it
    // reads TIMEOUT-1 and is still idle is the TIMEOUT-th one.
    assign w_hit    = i_count && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_expire = w_hit;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (i_clear || w_hit) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_load_ctrl.sv
// ----------------------------------------------------------------------------
// shift_load_ctrl
//
// Sequencer for the external 16-bit serial-in shift register that loads
// program words (e.g. a ROM image) into the Hack CPU system. Serial bits
// arrive MSB first over a valid/ready handshake and are steered into the
// shift register; after 16 bits the register's parallel output is offered
// as a word with an address over a second valid/ready handshake. A session
// ends after NUM_WORDS words and can be restarted with start_i.
//
// The shift register itself lives beside this block and must share resetb,
// so that word_o (a pass-through of shift_q_i) reads 0 out of reset.
//
// Optional feature (macro SHIFT_LOAD_TIMEOUT_EN):
//   When defined, a partial word that sees TIMEOUT consecutive cycles with
//   no accepted bit is abandoned (bit counter cleared, err_o pulses for one
//   cycle, state stays SHIFT). When undefined, err_o is tied 0 and a partial
//   word waits indefinitely.
//
// Parameters:
//   NUM_WORDS  words per load session (addr_o runs 0..NUM_WORDS-1)
//   ADDR_W     width of addr_o, 2**ADDR_W >= NUM_WORDS
//   TIMEOUT    idle-cycle limit for the optional timeout (>= 2)
//
// Ports:
//   clk           in   system clock, rising edge
//   resetb        in   asynchronous active-low reset
//   start_i       in   begin a load session (IDLE/DONE only)
//   ser_valid_i   in   serial bit valid
//   ser_data_i    in   serial bit, word MSB first
//   ser_ready_o   out  serial bit can be accepted (SHIFT)
//   shift_en_o    out  shift register enable (bit accepted this cycle)
//   shift_in_o    out  shift register serial input
//   shift_q_i     in   shift register parallel output
//   word_valid_o  out  assembled word available (PRESENT)
//   word_o        out  assembled word
//   word_ready_i  in   consumer accepts the word
//   addr_o        out  address of the current word
//   busy_o        out  SHIFT or PRESENT
//   done_o        out  DONE
//   err_o         out  timeout pulse (0 without the optional feature)
// ----------------------------------------------------------------------------
module shift_load_ctrl
    import shift_load_pkg::*;
#(
    parameter int NUM_WORDS = 32768,
    parameter int ADDR_W    = 15,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              start_i,
    input  logic              ser_valid_i,
    input  logic              ser_data_i,
    output logic              ser_ready_o,
    output logic              shift_en_o,
    output logic              shift_in_o,
    input  logic [WORD_W-1:0] shift_q_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    input  logic              word_ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    if ((2 ** ADDR_W) < NUM_WORDS) begin : g_bad_addr_w
        $error("shift_load_ctrl: ADDR_W too small for NUM_WORDS");
    end

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("shift_load_ctrl: TIMEOUT must be >= 2");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      w_addr_next;
    logic                   w_accept;
    logic                   w_timeout;

    // ------------------------------------------------------------------
    // Optional idle timeout on a partially received word
    // ------------------------------------------------------------------
`ifdef SHIFT_LOAD_TIMEOUT_EN
    logic w_idle_count;
    logic w_idle_clear;
    logic r_err;

    // Only a word that has started (bit_cnt != 0) can stall; an empty word
    // slot waits for its first bit without limit.
    assign w_idle_count = (r_state == SHIFT) && (r_bit_cnt != '0) && !ser_valid_i;
    assign w_idle_clear = (r_state != SHIFT) || ser_valid_i;

    shift_load_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .resetb   (resetb),
        .i_count  (w_idle_count),
        .i_clear  (w_idle_clear),
        .o_expire (w_timeout)
    );

    // Registered so the reported error is a clean single-cycle pulse in the
    // cycle after the partial word was dropped.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_addr    <= w_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_addr_next    = r_addr;
        w_accept       = 1'b0;
        ser_ready_o    = 1'b0;
        word_valid_o   = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next   = SHIFT;
                    w_bit_cnt_next = '0;
                    w_addr_next    = '0;
                end
            end

            SHIFT: begin
                ser_ready_o = 1'b1;
                busy_o      = 1'b1;
                w_accept    = ser_valid_i;
                if (w_accept) begin
                    if (is_last_bit(r_bit_cnt)) begin
                        w_state_next   = PRESENT;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end else if (w_timeout) begin
                    // Abandon the stalled partial word; the next bit starts
                    // a fresh word at the same address.
                    w_bit_cnt_next = '0;
                end
            end

            PRESENT: begin
                // Nothing shifts here, so shift_q_i (and word_o) is stable
                // for as long as the consumer back-pressures.
                word_valid_o = 1'b1;
                busy_o       = 1'b1;
                if (word_ready_i) begin
                    if (r_addr == LAST_ADDR) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = SHIFT;
                        w_addr_next  = r_addr + ADDR_W'(1);
                    end
                end
            end

            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    w_state_next   = SHIFT;
                    w_bit_cnt_next = '0;
                    w_addr_next    = '0;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register drive and word pass-through
    // ------------------------------------------------------------------
    assign shift_en_o = w_accept;
    assign shift_in_o = ser_data_i;
    assign word_o     = shift_q_i;
    assign addr_o     = r_addr;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_load_ctrl
//
// Bench for shift_load_ctrl with a behavioural 16-bit shift register beside
// it. Expected values come from a reference model that tracks the session
// phase, the bits received for the current word (a queue) and the word
// address; the word is rebuilt from the queue with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_shift_load_ctrl;

    localparam int NW = 2;
    localparam int AW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          start_i = 1'b0;
    logic          ser_valid_i = 1'b0;
    logic          ser_data_i = 1'b0;
    logic          word_ready_i = 1'b0;
    logic          ser_ready_o;
    logic          shift_en_o;
    logic          shift_in_o;
    logic          word_valid_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [15:0]   shift_q;
    logic [15:0]   word_o;
    logic [AW-1:0] addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External shift register sharing the controller's reset.
    always @(posedge clk or negedge resetb) begin
        if (!resetb) shift_q <= '0;
        else if (shift_en_o) shift_q <= {shift_q[14:0], shift_in_o};
    end

    shift_load_ctrl #(
        .NUM_WORDS (NW),
        .ADDR_W    (AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .start_i      (start_i),
        .ser_valid_i  (ser_valid_i),
        .ser_data_i   (ser_data_i),
        .ser_ready_o  (ser_ready_o),
        .shift_en_o   (shift_en_o),
        .shift_in_o   (shift_in_o),
        .shift_q_i    (shift_q),
        .word_valid_o (word_valid_o),
        .word_o       (word_o),
        .word_ready_i (word_ready_i),
        .addr_o       (addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // ------------------------------------------------------------------
    // Reference model: 0 = idle, 1 = loading bits, 2 = offering word,
    // 3 = session finished
    // ------------------------------------------------------------------
    int          m_phase;
    int          m_bits[$];
    int          m_addr;
    int          m_idle;
    bit          m_err;
    logic [15:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_bits.delete();
        m_addr  = 0;
        m_idle  = 0;
        m_err   = 0;
        m_word  = '0;
    endtask

    task automatic model_step();
        bit err_next;
        err_next = 0;
        case (m_phase)
            0, 3: begin
                if (start_i) begin
                    m_phase = 1;
                    m_addr  = 0;
                    m_idle  = 0;
                    m_bits.delete();
                end
            end
            1: begin
                if (ser_valid_i) begin
                    m_bits.push_back(int'(ser_data_i));
                    m_idle = 0;
                    if (m_bits.size() == 16) begin
                        int v;
                        v = 0;
                        foreach (m_bits[k]) v = v * 2 + m_bits[k];
                        m_word  = 16'(v);
                        m_bits.delete();
                        m_phase = 2;
                    end
                end else if (m_bits.size() != 0) begin
`ifdef SHIFT_LOAD_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == TO) begin
                        m_bits.delete();
                        m_idle   = 0;
                        err_next = 1;
                    end
`endif
                end
            end
            2: begin
                if (word_ready_i) begin
                    if (m_addr == NW - 1) begin
                        m_phase = 3;
                    end else begin
                        m_addr++;
                        m_phase = 1;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        m_err = err_next;
    endtask

    task automatic compare_outputs();
        chk("ser_ready",  ser_ready_o,  m_phase == 1);
        chk("shift_en",   shift_en_o,   (m_phase == 1) && ser_valid_i);
        chk("shift_in",   shift_in_o,   ser_data_i);
        chk("word_valid", word_valid_o, m_phase == 2);
        if (m_phase == 2) chk("word", word_o, m_word);
        chk("addr",       addr_o,       m_addr);
        chk("busy",       busy_o,       (m_phase == 1) || (m_phase == 2));
        chk("done",       done_o,       m_phase == 3);
        chk("err",        err_o,        m_err);
    endtask

    // One clock cycle: drive, check combinational outputs, clock, advance model.
    task automatic cyc(input bit st, input bit v, input bit d, input bit r);
        start_i      = st;
        ser_valid_i  = v;
        ser_data_i   = d;
        word_ready_i = r;
        #1;
        compare_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        start_i      = 0;
        ser_valid_i  = 0;
        ser_data_i   = 0;
        word_ready_i = 0;
        resetb       = 0;
        #2;
        chk("rst_ser_ready",  ser_ready_o,  0);
        chk("rst_shift_en",   shift_en_o,   0);
        chk("rst_word_valid", word_valid_o, 0);
        chk("rst_word",       word_o,       0);
        chk("rst_addr",       addr_o,       0);
        chk("rst_busy",       busy_o,       0);
        chk("rst_done",       done_o,       0);
        chk("rst_err",        err_o,        0);
        model_reset();
        @(negedge clk);
        resetb = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        for (int i = 15; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0);
            cyc(0, 1, w[i], 0);
        end
    endtask

    typedef struct {
        bit st, v, d, rdy;
        bit e_ready, e_en, e_wv, e_busy, e_done;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_err;
        int mode;

        tbl[0] = '{0, 1, 1, 0,  0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1,  0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 0,  1, 0, 0, 1, 0};
        tbl[4] = '{0, 1, 1, 0,  1, 1, 0, 1, 0};
        tbl[5] = '{1, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[6] = '{0, 1, 0, 1,  1, 1, 0, 1, 0};

        model_reset();
        do_reset();

        // Idle behaviour and session start, table driven.
        for (int i = 0; i < 7; i++) begin
            start_i      = tbl[i].st;
            ser_valid_i  = tbl[i].v;
            ser_data_i   = tbl[i].d;
            word_ready_i = tbl[i].rdy;
            #1;
            chk("tbl_ser_ready",  ser_ready_o,  tbl[i].e_ready);
            chk("tbl_shift_en",   shift_en_o,   tbl[i].e_en);
            chk("tbl_word_valid", word_valid_o, tbl[i].e_wv);
            chk("tbl_busy",       busy_o,       tbl[i].e_busy);
            chk("tbl_done",       done_o,       tbl[i].e_done);
            @(posedge clk);
            model_step();
            #1;
        end

        // Reset mid-word: the two bits already shifted must be discarded.
        do_reset();
        cyc(1, 0, 0, 0);
        send_word(16'hA5C3, 0);
        chk("first_word_valid", word_valid_o, 1);
        chk("first_word",       word_o,       16'hA5C3);
        chk("first_addr",       addr_o,       0);

        // Back-pressure with serial data still offered.
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, i[0], 0);
            chk("bp_word_valid", word_valid_o, 1);
            chk("bp_word",       word_o,       16'hA5C3);
            chk("bp_ser_ready",  ser_ready_o,  0);
        end
        cyc(0, 0, 0, 1);
        chk("rel_addr",      addr_o,      1);
        chk("rel_ser_ready", ser_ready_o, 1);

        send_word(16'h1234, 0);
        chk("second_word", word_o, 16'h1234);
        cyc(1, 0, 0, 1);   // start together with DONE entry is not honoured
        chk("end_done", done_o, 1);
        chk("end_addr", addr_o, 1);
        cyc(0, 0, 0, 0);
        chk("still_done", done_o, 1);
        cyc(1, 0, 0, 0);
        chk("restart_addr", addr_o, 0);
        chk("restart_busy", busy_o, 1);

        // Gapped serial input.
        send_word(16'hFFFF, 1);
        chk("gap_word0", word_o, 16'hFFFF);
        cyc(0, 0, 0, 1);
        send_word(16'h0001, 1);
        chk("gap_word1", word_o, 16'h0001);
        chk("gap_addr1", addr_o, 1);
        cyc(0, 0, 0, 1);
        chk("gap_done", done_o, 1);

        // Stalled partial word.
        cyc(1, 0, 0, 0);
        for (int i = 15; i >= 11; i--) cyc(0, 1, i[0] ^ 1'b0 ? 1'b1 : 1'b0, 0);
        n_err = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if (err_o) n_err++;
        end
`ifdef SHIFT_LOAD_TIMEOUT_EN
        chk("timeout_pulses", n_err, 1);
        send_word(16'hBEEF, 0);
`else
        chk("timeout_pulses", n_err, 0);
        begin
            logic [15:0] w;
            w = 16'hBEEF;
            for (int i = 10; i >= 1; i--) cyc(0, 1, w[i], 0);
            chk("partial_no_word", word_valid_o, 0);
            cyc(0, 1, w[0], 0);
        end
`endif
        chk("timeout_word_valid", word_valid_o, 1);
`ifdef SHIFT_LOAD_TIMEOUT_EN
        chk("timeout_word", word_o, 16'hBEEF);
`else
        // First 5 bits were the low bits of 15..11 pattern; rebuilt by model.
        chk("timeout_word", word_o, m_word);
`endif
        cyc(0, 0, 0, 1);

        // Randomised traffic against the model.
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            bit v;
            if ((c % 64) == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       v = ($urandom_range(0, 3) != 0);
                1:       v = ($urandom_range(0, 9) == 0);
                default: v = 1'b1;
            endcase
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 15) == 0, v, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
